// File: rtl/cmb_pkg.sv
// Shared encodings for the CMB board counter blocks.
package cmb_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_SAT  = 1'b0,
    MODE_WRAP = 1'b1
  } mode_e;

endpackage

// File: rtl/tick_edge_detect.sv
// Two-flop synchroniser plus a delay flop; emits a one-cycle pulse per rising
// edge of an asynchronous input (slow ticks, push-buttons).
module tick_edge_detect (
  input  logic fpga_clk,
  input  logic sys_init_ctrl,
  input  logic sig_in,
  output logic rise_pulse
);

  logic sync1;
  logic sync2;
  logic delay;

  // NOTE: non-blocking assignments make the three flops sample together;
  // blocking here would collapse the chain into a single stage.
  always_ff @(posedge fpga_clk) begin
    if (sys_init_ctrl) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      delay <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      delay <= sync2;
    end
  end

  assign rise_pulse = sync2 & ~delay;

endmodule

// File: rtl/led_tick_counter.sv
// Up/down tick counter driving an LED bank, with wrap/saturate, clamped
// parallel load and a registered terminal-count pulse.
module led_tick_counter
  import cmb_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
  input  logic             fpga_clk,
  input  logic             sys_init_ctrl,
  input  logic             tick_in,
  input  logic             en,
  input  logic             dir,
  input  logic             wrap_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic             tick;
  logic             at_term;
  logic             wrap;
  logic [WIDTH-1:0] next_led;
  logic             next_tc;

  tick_edge_detect u_tick_edge (
    .fpga_clk      (fpga_clk),
    .sys_init_ctrl (sys_init_ctrl),
    .sig_in        (tick_in),
    .rise_pulse    (tick)
  );

  assign wrap    = (wrap_en == MODE_WRAP);
  assign at_term = (dir == DIR_UP) ? (led == MAX_COUNT) : (led == ZERO);

  // NOTE: every output gets a default before the branches so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_led = led;
    next_tc  = 1'b0;
    if (load) begin
      next_led = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
    end else if (tick && en) begin
      next_tc = at_term;
      if (dir == DIR_UP) begin
        if (at_term) next_led = wrap ? ZERO : led;
        else         next_led = led + ONE;
      end else begin
        if (at_term) next_led = wrap ? MAX_COUNT : led;
        else         next_led = led - ONE;
      end
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (sys_init_ctrl) begin
      led <= ZERO;
      tc  <= 1'b0;
    end else begin
      led <= next_led;
      tc  <= next_tc;
    end
  end

endmodule

// File: tb/tb_led_tick_counter.sv
// Bench for led_tick_counter: three configurations share one stimulus stream,
// a per-cycle model comparison and directed literal checks.
module tb_led_tick_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick_in, en, dir, wrap_en, load;
  logic [7:0] load_val;
  logic [7:0] led_a, led_b;
  logic [3:0] led_c;
  logic       tc_a, tc_b, tc_c;

  int checks = 0;
  int errors = 0;

  led_tick_counter u_a (
    .fpga_clk(clk), .sys_init_ctrl(rst), .tick_in(tick_in), .en(en), .dir(dir),
    .wrap_en(wrap_en), .load(load), .load_val(load_val), .led(led_a), .tc(tc_a)
  );

  led_tick_counter #(.WIDTH(8), .MAX_COUNT(8'd9)) u_b (
    .fpga_clk(clk), .sys_init_ctrl(rst), .tick_in(tick_in), .en(en), .dir(dir),
    .wrap_en(wrap_en), .load(load), .load_val(load_val), .led(led_b), .tc(tc_b)
  );

  led_tick_counter #(.WIDTH(4), .MAX_COUNT(4'd15)) u_c (
    .fpga_clk(clk), .sys_init_ctrl(rst), .tick_in(tick_in), .en(en), .dir(dir),
    .wrap_en(wrap_en), .load(load), .load_val(load_val[3:0]), .led(led_c), .tc(tc_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a tick_in level first sampled high (after a low sample) is counted
  // two edges later; reset forgets all samples.
  int m_led[3];
  bit m_tc[3];
  bit samp[$];
  bit model_on = 1'b0;
  int mx[3]    = '{255, 9, 15};
  int lmask[3] = '{255, 255, 15};

  always @(posedge clk) begin : model
    bit tk;
    int lv;
    if (rst) begin
      model_on = 1'b1;
      samp = '{0, 0, 0};
      for (int i = 0; i < 3; i++) begin
        m_led[i] = 0;
        m_tc[i]  = 1'b0;
      end
    end else begin
      tk = samp[1] && !samp[2];
      for (int i = 0; i < 3; i++) begin
        lv = int'(load_val) & lmask[i];
        m_tc[i] = 1'b0;
        if (load) begin
          m_led[i] = (lv > mx[i]) ? mx[i] : lv;
        end else if (tk && en) begin
          if (!dir) begin
            if (m_led[i] == mx[i]) begin
              m_tc[i] = 1'b1;
              if (wrap_en) m_led[i] = 0;
            end else m_led[i] = m_led[i] + 1;
          end else begin
            if (m_led[i] == 0) begin
              m_tc[i] = 1'b1;
              if (wrap_en) m_led[i] = mx[i];
            end else m_led[i] = m_led[i] - 1;
          end
        end
      end
      samp.push_front(tick_in);
      void'(samp.pop_back());
    end
  end

  int tcn[3] = '{0, 0, 0};

  always @(posedge clk) begin
    #1;
    if (model_on) begin
      check("model_led_a", 32'(led_a), 32'(m_led[0]));
      check("model_tc_a",  32'(tc_a),  32'(m_tc[0]));
      check("model_led_b", 32'(led_b), 32'(m_led[1]));
      check("model_tc_b",  32'(tc_b),  32'(m_tc[1]));
      check("model_led_c", 32'(led_c), 32'(m_led[2]));
      check("model_tc_c",  32'(tc_c),  32'(m_tc[2]));
      if (tc_a === 1'b1) tcn[0]++;
      if (tc_b === 1'b1) tcn[1]++;
      if (tc_c === 1'b1) tcn[2]++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_val = v;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic tick();
    tick_in = 1'b1;
    cyc(3);
    tick_in = 1'b0;
    cyc(3);
  endtask

  int n0;
  int down_exp[4] = '{1, 0, 0, 0};

  initial begin
    rst = 1'b1; tick_in = 1'b0; en = 1'b1; dir = 1'b0; wrap_en = 1'b1;
    load = 1'b0; load_val = 8'h00;
    cyc(2);
    check("reset_led_a", 32'(led_a), 32'h0);
    check("reset_tc_a",  32'(tc_a),  32'h0);
    check("reset_led_c", 32'(led_c), 32'h0);
    rst = 1'b0;
    cyc(1);

    // Reset mid-count with a tick in flight
    do_load(8'h36);
    tick();
    check("count_to_37", 32'(led_a), 32'h37);
    tick_in = 1'b1;
    cyc(1);
    rst = 1'b1;
    tick_in = 1'b0;
    cyc(1);
    check("midcount_reset_led", 32'(led_a), 32'h0);
    check("midcount_reset_tc",  32'(tc_a),  32'h0);
    rst = 1'b0;
    cyc(4);
    check("inflight_dropped", 32'(led_a), 32'h0);

    // tick_in high while reset releases counts once
    rst = 1'b1;
    tick_in = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(4);
    check("high_at_release", 32'(led_a), 32'h1);
    tick_in = 1'b0;
    cyc(3);

    // Up wrap with latency
    do_load(8'hFE);
    n0 = tcn[0];
    tick_in = 1'b1;
    @(posedge clk); #1;
    check("lat_edge_k",   32'(led_a), 32'hFE);
    @(posedge clk); #1;
    check("lat_edge_k1",  32'(led_a), 32'hFE);
    @(posedge clk); #1;
    check("lat_edge_k2",  32'(led_a), 32'hFF);
    check("lat_tc_noterm", 32'(tc_a), 32'h0);
    cyc(2);
    tick_in = 1'b0;
    cyc(3);
    tick_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("wrap_to_00", 32'(led_a), 32'h00);
    check("wrap_tc_hi", 32'(tc_a),  32'h1);
    @(posedge clk); #1;
    check("wrap_tc_lo", 32'(tc_a),  32'h0);
    cyc(1);
    tick_in = 1'b0;
    cyc(3);
    tick();
    check("wrap_to_01", 32'(led_a), 32'h01);
    check("wrap_tc_count", 32'(tcn[0] - n0), 32'd1);

    // Down saturate on MAX_COUNT=9
    dir = 1'b1;
    wrap_en = 1'b0;
    do_load(8'd2);
    check("dsat_load", 32'(led_b), 32'd2);
    n0 = tcn[1];
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("dsat_step%0d", i), 32'(led_b), 32'(down_exp[i]));
    end
    check("dsat_tc_count", 32'(tcn[1] - n0), 32'd2);

    // Load clamp colliding with a tick
    dir = 1'b0;
    do_load(8'd5);
    check("coll_preload", 32'(led_b), 32'd5);
    n0 = tcn[1];
    tick_in = 1'b1;
    cyc(2);
    load = 1'b1;
    load_val = 8'd15;
    @(posedge clk); #1;
    check("clamp_led", 32'(led_b), 32'd9);
    check("clamp_tc",  32'(tc_b),  32'h0);
    @(negedge clk);
    load = 1'b0;
    tick_in = 1'b0;
    cyc(4);
    check("coll_discard", 32'(led_b), 32'd9);
    check("coll_no_tc", 32'(tcn[1] - n0), 32'd0);

    // Enable gating
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("en_low_hold", 32'(led_a), 32'd15);
    en = 1'b1;
    tick();
    check("en_high_inc", 32'(led_a), 32'd16);

    // Down wrap at width 4
    dir = 1'b1;
    wrap_en = 1'b1;
    do_load(8'd0);
    check("w4_load0", 32'(led_c), 32'd0);
    n0 = tcn[2];
    tick_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("w4_wrap_led", 32'(led_c), 32'd15);
    check("w4_tc_hi",    32'(tc_c),  32'h1);
    @(posedge clk); #1;
    check("w4_tc_lo",    32'(tc_c),  32'h0);
    cyc(1);
    tick_in = 1'b0;
    cyc(3);
    check("w4_tc_count", 32'(tcn[2] - n0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_tick_counter.md
# led_tick_counter

Parametrised successor to the 8-bit LED tick counter on the CMB board. It counts rising edges of a slow tick input, such as the 1 Hz divider output, in the `fpga_clk` domain and drives the result onto an LED bank. Generalisations over the 8-bit block:
- parametrised width and terminal value;
- up/down direction;
- wrap or saturate mode;
- synchronous parallel load;
- count enable;
- terminal-count pulse.

## Interface
Parameters:
- `WIDTH`, default 8: counter and LED width, 2..32.
- `MAX_COUNT`, default 2**WIDTH-1: terminal value for up-count. Must be ≥ 1 and ≤ 2**WIDTH-1.

Ports:
- `fpga_clk`  in  1  system clock; the only clock.
- `sys_init_ctrl`  in  1  reset, synchronous, active-high.
- `tick_in`  in  1  asynchronous slow square wave (e.g. `clk_1Hz`). Only its rising edge counts.
- `en`  in  1  count enable. Gates ticks only, not load.
- `dir`  in  1  0 = up, 1 = down.
- `wrap_en`  in  1  1 = wrap at the terminal value, 0 = saturate.
- `load`  in  1  synchronous parallel load strobe.
- `load_val`  in  WIDTH  value to load.
- `led`  out  WIDTH  registered count value.
- `tc`  out  1  registered one-cycle terminal-count pulse.

## Operation
- **Tick path:**
  - `tick_in` passes through a 2-flop synchroniser, then a 1-flop delay.
  - Internal `tick` = sync2 & ~delay. This gives exactly one `fpga_clk` cycle per rising edge of `tick_in`.
- **Priority per `fpga_clk` edge:** `sys_init_ctrl` > `load` > (`tick` & `en`) > hold.
- **Reset:**
  - `led` = 0 and `tc` = 0.
  - Synchroniser and delay flops are cleared to 0.
  - A `tick_in` that is high when reset is released counts as one rising edge once it has propagated through the synchroniser.
- **Load:**
  - `led` ← min(`load_val`, `MAX_COUNT`).
  - `tc` = 0.
  - A `tick` coinciding with `load` is discarded.
- **Count, up (`dir`=0):**
  - `led` < `MAX_COUNT`: `led` + 1.
  - `led` = `MAX_COUNT`: `led` → 0 if `wrap_en`, otherwise hold.
- **Count, down (`dir`=1):**
  - `led` > 0: `led` − 1.
  - `led` = 0: `led` → `MAX_COUNT` if `wrap_en`, otherwise hold.
- **`tc`:**
  - Asserts for exactly one cycle when a counted tick finds `led` at the terminal value for the current direction (`MAX_COUNT` up, 0 down).
  - This applies in both wrap and saturate modes, so repeated ticks while saturated pulse `tc` each time.
- **Changes on `dir` and `wrap_en`** take effect on the next counted tick. No state depends on their history.
- **`en` low:** a `tick` arriving in that cycle is lost, not deferred.
- **Arithmetic:** WIDTH-bit unsigned, with no intermediate overflow. Comparisons are made against `MAX_COUNT` and never rely on natural 2**WIDTH rollover.

## Timing
- **Tick latency:**
  - `tick_in` first sampled high at edge k → `tick` high during cycle k+1 → `led` and `tc` update at edge k+2.
  - `tc` is high for the cycle k+2..k+3 only.
- **Load latency:** `load` high at edge k → `led` valid after edge k.
- **Reset:** `sys_init_ctrl` high at edge k → all outputs 0 after edge k. Reset mid-count drops any in-flight `tick`.
- **Minimum `tick_in` timing:** high and low phases of ≥ 2 `fpga_clk` periods each. Shorter pulses may be missed; this is not an error condition.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- **Shared package (`cmb_pkg`):**
  - `DIR_UP` = 0, `DIR_DOWN` = 1.
  - `MODE_SAT` = 0, `MODE_WRAP` = 1.
- **Sub-module `tick_edge_detect`:** the synchroniser plus rising-edge pulse generator, with ports `fpga_clk`, `sys_init_ctrl`, `sig_in`, `rise_pulse`. It is reusable for push-buttons.
- **Top level:** the counter register, the next-value mux, the load clamp and the `tc` register.

## Test plan
- **Reset mid-count:** `WIDTH`=8, default `MAX_COUNT`; count to 0x37, assert `sys_init_ctrl` for 1 cycle → `led` = 0x00 and `tc` = 0 next cycle. No count occurs from a tick that was in flight.
- **Up wrap:** up, wrap, `load_val`=0xFE, then 3 ticks → `led` goes 0xFF, 0x00, 0x01. `tc` pulses once, at the 0xFF→0x00 step, with tick-to-`led` latency of 2 cycles from first sampled high.
- **Down saturate:** `MAX_COUNT`=9, down, saturate; load 2, then 4 ticks → `led` goes 1, 0, 0, 0. `tc` pulses on the 3rd and 4th ticks.
- **Load clamp and collision:** `MAX_COUNT`=9; `load_val`=15 with `load` in the same cycle as `tick` → `led` = 9, `tc` = 0, and the tick is discarded.
- **Enable gating:** `en`=0 across 5 ticks → `led` unchanged. Then `en`=1 and 1 tick → `led` +1.
- **Down wrap at width 4:** `WIDTH`=4, `MAX_COUNT`=15, down, wrap, from 0, one tick → `led` = 15 and `tc` = 1 for one cycle.
